// File: rtl/axi_sram_slave_if.sv
// rtl/axi_sram_slave_if.sv - AXI4 read/write channel bundle between a burst master and the SRAM slave
interface axi_sram_slave_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI4 burst slave over a word-addressed on-chip SRAM
module axi_sram_slave #(
    parameter int MEM_AW       = 12,
    parameter int READ_LATENCY = 0,
    parameter int ID_W         = 4
) (
    input  logic            clk,
    input  logic            rst,
    axi_sram_slave_if.slave s
);
    localparam int         DEPTH     = 1 << MEM_AW;
    localparam logic [3:0] WAIT_LAST = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_e;

    logic [31:0] mem_q [DEPTH];

    r_state_e          r_state_q, r_state_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [MEM_AW-1:0] r_idx_q, r_idx_d;
    logic [7:0]        r_len_q, r_len_d;
    logic [7:0]        r_cnt_q, r_cnt_d;
    logic [3:0]        r_wait_q, r_wait_d;
    logic              r_err_q, r_err_d;
    logic              r_fixed_q, r_fixed_d;

    w_state_e          w_state_q, w_state_d;
    logic [ID_W-1:0]   w_id_q, w_id_d;
    logic [MEM_AW-1:0] w_idx_q, w_idx_d;
    logic [7:0]        w_len_q, w_len_d;
    logic [7:0]        w_cnt_q, w_cnt_d;
    logic              w_err_q, w_err_d;
    logic              w_fixed_q, w_fixed_d;

    logic arready_o, rvalid_o, awready_o, wready_o, bvalid_o;
    logic r_beat_last, w_beat_last, w_we;

    assign r_beat_last = (r_cnt_q == r_len_q);
    assign w_beat_last = (w_cnt_q == w_len_q);

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_wait_d  = r_wait_q;
        r_err_d   = r_err_q;
        r_fixed_d = r_fixed_q;
        arready_o = 1'b0;
        rvalid_o  = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                arready_o = 1'b1;
                if (s.arvalid) begin
                    r_id_d    = s.arid;
                    r_idx_d   = s.araddr[MEM_AW+1:2];
                    r_len_d   = s.arlen;
                    r_cnt_d   = 8'd0;
                    r_wait_d  = 4'd0;
                    r_err_d   = s.arburst[1];
                    r_fixed_d = (s.arburst == 2'b00);
                    r_state_d = (READ_LATENCY > 0) ? R_WAIT : R_BURST;
                end
            end
            R_WAIT: begin
                if (r_wait_q == WAIT_LAST) r_state_d = R_BURST;
                else                       r_wait_d  = r_wait_q + 4'd1;
            end
            R_BURST: begin
                rvalid_o = 1'b1;
                if (s.rready) begin
                    r_cnt_d = r_cnt_q + 8'd1;
                    if (!r_fixed_q) r_idx_d = r_idx_q + 1'b1;
                    if (r_beat_last) r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        w_fixed_d = w_fixed_q;
        awready_o = 1'b0;
        wready_o  = 1'b0;
        bvalid_o  = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                awready_o = 1'b1;
                if (s.awvalid) begin
                    w_id_d    = s.awid;
                    w_idx_d   = s.awaddr[MEM_AW+1:2];
                    w_len_d   = s.awlen;
                    w_cnt_d   = 8'd0;
                    w_err_d   = s.awburst[1];
                    w_fixed_d = (s.awburst == 2'b00);
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready_o = 1'b1;
                if (s.wvalid) begin
                    w_cnt_d = w_cnt_q + 8'd1;
                    if (!w_fixed_q) w_idx_d = w_idx_q + 1'b1;
                    // Beat count ends the burst; a disagreeing wlast only poisons the response.
                    if (s.wlast != w_beat_last) w_err_d = 1'b1;
                    if (w_beat_last) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                bvalid_o = 1'b1;
                if (s.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_wait_q  <= '0;
            r_err_q   <= 1'b0;
            r_fixed_q <= 1'b0;
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            w_fixed_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_wait_q  <= r_wait_d;
            r_err_q   <= r_err_d;
            r_fixed_q <= r_fixed_d;
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            w_fixed_q <= w_fixed_d;
        end
    end

    // Array is not reset; a same-edge read beat sees the pre-write word.
    assign w_we = s.wvalid & s.wready & ~w_err_q;

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s.wstrb[b]) mem_q[w_idx_q][8*b +: 8] <= s.wdata[8*b +: 8];
            end
        end
    end

    assign s.arready = arready_o & ~rst;
    assign s.rvalid  = rvalid_o & ~rst;
    assign s.rlast   = s.rvalid & r_beat_last;
    assign s.rresp   = (s.rvalid & r_err_q) ? 2'b10 : 2'b00;
    assign s.rdata   = (s.rvalid & ~r_err_q) ? mem_q[r_idx_q] : 32'd0;
    assign s.rid     = s.rvalid ? r_id_q : '0;

    assign s.awready = awready_o & ~rst;
    assign s.wready  = wready_o & ~rst;
    assign s.bvalid  = bvalid_o & ~rst;
    assign s.bresp   = (s.bvalid & w_err_q) ? 2'b10 : 2'b00;
    assign s.bid     = s.bvalid ? w_id_q : '0;

    logic unused_ok;
    assign unused_ok = ^{s.arsize, s.awsize, s.araddr[31:MEM_AW+2], s.araddr[1:0],
                         s.awaddr[31:MEM_AW+2], s.awaddr[1:0], s.arburst[0], s.awburst[0]};
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - randomized self-checking bench for axi_sram_slave against a word-array model
module tb_axi_sram_slave;
    localparam int ID_W   = 4;
    localparam int MEM_AW = 12;
    localparam int DEPTH  = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_sram_slave_if #(.ID_W(ID_W)) bus ();
    axi_sram_slave_if #(.ID_W(ID_W)) lbus ();

    axi_sram_slave #(.MEM_AW(MEM_AW), .READ_LATENCY(0), .ID_W(ID_W)) u_dut (.clk(clk), .rst(rst), .s(bus));
    axi_sram_slave #(.MEM_AW(MEM_AW), .READ_LATENCY(3), .ID_W(ID_W)) u_lat (.clk(clk), .rst(rst), .s(lbus));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          hs_cyc;
        int          idx;
        logic [31:0] data;
        logic [3:0]  strb;
    } wbeat_t;

    logic [31:0] mdl [DEPTH];
    wbeat_t      wlog [$];

    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    int          rd_cyc  [16];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic int idx_of(input logic [31:0] addr, input int beat, input logic [1:0] burst);
        int base;
        base = int'(addr[13:2]);
        return (burst == 2'b00) ? base : (base + beat) % DEPTH;
    endfunction

    function automatic logic [31:0] expect_at(input int idx, input int hs);
        logic [31:0] v;
        v = mdl[idx];
        foreach (wlog[k]) if (wlog[k].idx == idx && wlog[k].hs_cyc < hs) v = merge(v, wlog[k].data, wlog[k].strb);
        return v;
    endfunction

    task automatic apply_wlog();
        foreach (wlog[k]) mdl[wlog[k].idx] = merge(mdl[wlog[k].idx], wlog[k].data, wlog[k].strb);
        wlog.delete();
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [ID_W-1:0] id, input int early, input bit gaps,
                            output logic [1:0] resp, output logic [ID_W-1:0] bid_o, output bit ok);
        int t;
        wbeat_t e;
        ok = 1'b1; resp = 2'bxx; bid_o = 'x;
        bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len); bus.awsize = 3'd2;
        bus.awburst = burst; bus.awvalid = 1'b1;
        t = 0;
        while (!bus.awready && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) ok = 1'b0;
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int b = 0; b <= len && ok; b++) begin
            if (gaps) while ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
            bus.wvalid = 1'b1; bus.wdata = wr_data[b]; bus.wstrb = wr_strb[b];
            bus.wlast = (early >= 0) ? (b == early) : (b == len);
            t = 0;
            while (!bus.wready && t < 50) begin @(posedge clk); #1; t++; end
            if (t >= 50) ok = 1'b0;
            e.hs_cyc = cyc; e.idx = idx_of(addr, b, burst); e.data = wr_data[b]; e.strb = wr_strb[b];
            if (ok) wlog.push_back(e);
            @(posedge clk); #1;
            bus.wvalid = 1'b0; bus.wlast = 1'b0;
        end
        if (gaps) while ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
        t = 0;
        while (!bus.bvalid && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) ok = 1'b0;
        resp = bus.bresp; bid_o = bus.bid;
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    // rmode: 0 always ready, 1 toggles every cycle, 2 random
    task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [ID_W-1:0] id, input int rmode,
                           output int nbeats, output bit stable_ok, output logic [ID_W-1:0] rid_o,
                           output int ar_cyc);
        int t;
        bit rdy, tog, stalled;
        logic [31:0] pd;
        logic [1:0] pr;
        logic pl;
        stable_ok = 1'b1; nbeats = 0; tog = 1'b0; stalled = 1'b0; rid_o = 'x;
        pd = '0; pr = '0; pl = 1'b0;
        bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len); bus.arsize = 3'd2;
        bus.arburst = burst; bus.arvalid = 1'b1;
        t = 0;
        while (!bus.arready && t < 50) begin @(posedge clk); #1; t++; end
        ar_cyc = cyc;
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        t = 0;
        while (nbeats <= len && t < 400) begin
            rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            bus.rready = rdy;
            if (bus.rvalid) begin
                if (stalled && (bus.rdata !== pd || bus.rlast !== pl || bus.rresp !== pr)) stable_ok = 1'b0;
                if (rdy) begin
                    rd_data[nbeats] = bus.rdata; rd_resp[nbeats] = bus.rresp;
                    rd_last[nbeats] = bus.rlast; rd_cyc[nbeats] = cyc; rid_o = bus.rid;
                    nbeats++; stalled = 1'b0;
                end else begin
                    stalled = 1'b1; pd = bus.rdata; pl = bus.rlast; pr = bus.rresp;
                end
            end
            @(posedge clk); #1;
            t++;
        end
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [49:0] got;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got = {bus.arready, bus.awready, bus.rvalid, bus.rlast, bus.wready, bus.bvalid,
               bus.rid, bus.bid, bus.rresp, bus.bresp, bus.rdata};
        n_checks++;
        if (got !== 50'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", got); end
        got = {lbus.arready, lbus.awready, lbus.rvalid, lbus.rlast, lbus.wready, lbus.bvalid,
               lbus.rid, lbus.bid, lbus.rresp, lbus.bresp, lbus.rdata};
        n_checks++;
        if (got !== 50'd0) begin n_fail++; $display("FAIL reset_outputs_lat: got %h expected 0", got); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b expected 11000",
                     {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid});
        end
    endtask

    task automatic test_single();
        logic [1:0] resp; logic [ID_W-1:0] id_o; bit ok, st; int nb, arc;
        wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
        do_write(32'h100, 0, 2'b01, 4'd3, -1, 1'b0, resp, id_o, ok);
        n_checks++;
        if (!ok || resp !== 2'b00 || id_o !== 4'd3) begin
            n_fail++; $display("FAIL single_write_resp: got ok=%0d bresp=%b bid=%h expected 1/00/3", ok, resp, id_o);
        end
        apply_wlog();
        do_read(32'h100, 0, 2'b01, 4'd5, 0, nb, st, id_o, arc);
        n_checks++;
        if (nb != 1 || rd_data[0] !== mdl[64] || rd_last[0] !== 1'b1 || rd_resp[0] !== 2'b00 || id_o !== 4'd5) begin
            n_fail++;
            $display("FAIL single_read: got beats=%0d data=%h last=%b resp=%b rid=%h expected 1/%h/1/00/5",
                     nb, rd_data[0], rd_last[0], rd_resp[0], id_o, mdl[64]);
        end
        n_checks++;
        if (rd_cyc[0] - arc != 1) begin n_fail++; $display("FAIL single_read_latency: got %0d expected 1", rd_cyc[0] - arc); end
        n_checks++;
        if (bus.arready !== 1'b1 || bus.rvalid !== 1'b0) begin
            n_fail++; $display("FAIL single_read_return_idle: got arready=%b rvalid=%b expected 1/0", bus.arready, bus.rvalid);
        end
    endtask

    task automatic test_burst16();
        logic [1:0] resp; logic [ID_W-1:0] id_o; bit ok, st; int nb, arc;
        for (int i = 0; i < 16; i++) begin wr_data[i] = 32'(i); wr_strb[i] = 4'hF; end
        do_write(32'h1C0, 15, 2'b01, 4'd1, -1, 1'b0, resp, id_o, ok);
        n_checks++;
        if (!ok || resp !== 2'b00) begin n_fail++; $display("FAIL burst16_write: got ok=%0d bresp=%b expected 1/00", ok, resp); end
        apply_wlog();
        do_read(32'h1C0, 15, 2'b01, 4'd2, 1, nb, st, id_o, arc);
        n_checks++;
        if (nb != 16) begin n_fail++; $display("FAIL burst16_beats: got %0d expected 16", nb); end
        for (int i = 0; i < nb; i++) begin
            n_checks++;
            if (rd_data[i] !== mdl[idx_of(32'h1C0, i, 2'b01)] || rd_last[i] !== (i == 15) || rd_resp[i] !== 2'b00) begin
                n_fail++;
                $display("FAIL burst16_beat%0d: got data=%h last=%b resp=%b expected %h/%b/00",
                         i, rd_data[i], rd_last[i], rd_resp[i], mdl[idx_of(32'h1C0, i, 2'b01)], i == 15);
            end
        end
        n_checks++;
        if (!st) begin n_fail++; $display("FAIL burst16_stall_stable: got %0d expected 1", st); end
    endtask

    task automatic test_partial_strobe();
        logic [1:0] resp; logic [ID_W-1:0] id_o; bit ok, st; int nb, arc;
        wr_data[0] = 32'h11223344; wr_strb[0] = 4'hF;
        do_write(32'h200, 0, 2'b01, 4'd0, -1, 1'b0, resp, id_o, ok);
        apply_wlog();
        wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'b0101;
        do_write(32'h200, 0, 2'b01, 4'd0, -1, 1'b0, resp, id_o, ok);
        apply_wlog();
        do_read(32'h200, 0, 2'b01, 4'd0, 0, nb, st, id_o, arc);
        n_checks++;
        if (nb != 1 || rd_data[0] !== mdl[128]) begin
            n_fail++; $display("FAIL partial_strobe: got %h expected %h", rd_data[0], mdl[128]);
        end
    endtask

    task automatic test_latency();
        int t, acc;
        lbus.arid = 4'd7; lbus.araddr = 32'h0; lbus.arlen = 8'd0; lbus.arsize = 3'd2;
        lbus.arburst = 2'b01; lbus.arvalid = 1'b1; lbus.rready = 1'b1;
        t = 0;
        while (!lbus.arready && t < 50) begin @(posedge clk); #1; t++; end
        acc = cyc;
        @(posedge clk); #1;
        lbus.arvalid = 1'b0;
        t = 0;
        while (!lbus.rvalid && t < 50) begin @(posedge clk); #1; t++; end
        n_checks++;
        if (cyc - acc != 4) begin n_fail++; $display("FAIL latency3_first_rvalid: got %0d expected 4", cyc - acc); end
        n_checks++;
        if (lbus.rlast !== 1'b1 || lbus.rid !== 4'd7) begin
            n_fail++; $display("FAIL latency3_beat: got rlast=%b rid=%h expected 1/7", lbus.rlast, lbus.rid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        logic [1:0] resp; logic [ID_W-1:0] id_o; bit ok, st; int nb, arc;
        wr_data[0] = $urandom; wr_data[1] = $urandom; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
        do_write(32'h3FFC, 1, 2'b01, 4'd4, -1, 1'b0, resp, id_o, ok);
        apply_wlog();
        do_read(32'h3FFC, 1, 2'b01, 4'd4, 0, nb, st, id_o, arc);
        n_checks++;
        if (nb != 2 || rd_data[0] !== mdl[DEPTH-1] || rd_data[1] !== mdl[0]) begin
            n_fail++;
            $display("FAIL wrap_read: got %h %h expected %h %h", rd_data[0], rd_data[1], mdl[DEPTH-1], mdl[0]);
        end
    endtask

    task automatic test_errors();
        logic [1:0] resp; logic [ID_W-1:0] id_o; bit ok, st; int nb, arc;
        do_read(32'h100, 3, 2'b10, 4'd9, 2, nb, st, id_o, arc);
        n_checks++;
        if (nb != 4) begin n_fail++; $display("FAIL err_read_beats: got %0d expected 4", nb); end
        for (int i = 0; i < nb; i++) begin
            n_checks++;
            if (rd_resp[i] !== 2'b10 || rd_data[i] !== 32'd0 || rd_last[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL err_read_beat%0d: got resp=%b data=%h last=%b expected 10/0/%b",
                         i, rd_resp[i], rd_data[i], rd_last[i], i == 3);
            end
        end
        for (int i = 0; i < 3; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
        do_write(32'h3000, 2, 2'b01, 4'd6, 0, 1'b0, resp, id_o, ok);
        n_checks++;
        if (!ok || resp !== 2'b10 || id_o !== 4'd6) begin
            n_fail++; $display("FAIL err_early_wlast: got ok=%0d bresp=%b bid=%h expected 1/10/6", ok, resp, id_o);
        end
        wlog.delete();
    endtask

    task automatic test_concurrent();
        logic [1:0] resp; logic [ID_W-1:0] id_o, rid_o; bit ok, st; int nb, arc;
        for (int i = 0; i < 4; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
        do_write(32'h400, 3, 2'b01, 4'd0, -1, 1'b0, resp, id_o, ok);
        apply_wlog();
        for (int i = 0; i < 4; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
        fork
            do_write(32'h400, 3, 2'b01, 4'd1, -1, 1'b0, resp, id_o, ok);
            do_read(32'h400, 3, 2'b01, 4'd2, 0, nb, st, rid_o, arc);
        join
        n_checks++;
        if (nb != 4 || !ok) begin n_fail++; $display("FAIL concurrent_complete: got beats=%0d wok=%0d expected 4/1", nb, ok); end
        for (int i = 0; i < nb; i++) begin
            n_checks++;
            if (rd_data[i] !== expect_at(idx_of(32'h400, i, 2'b01), rd_cyc[i])) begin
                n_fail++;
                $display("FAIL concurrent_beat%0d: got %h expected %h", i, rd_data[i],
                         expect_at(idx_of(32'h400, i, 2'b01), rd_cyc[i]));
            end
        end
        apply_wlog();
    endtask

    task automatic test_random();
        logic [1:0] resp, burst; logic [ID_W-1:0] id_o; bit ok, st; int nb, arc, len, w;
        logic [31:0] addr;
        for (int blk = 0; blk < 16; blk++) begin
            for (int i = 0; i < 16; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
            do_write(32'h2000 + 32'(blk * 64), 15, 2'b01, 4'd0, -1, 1'b1, resp, id_o, ok);
            apply_wlog();
        end
        for (int it = 0; it < 16; it++) begin
            len   = $urandom_range(0, 15);
            burst = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
            w     = 2048 + $urandom_range(0, 239);
            addr  = 32'(w * 4) | 32'($urandom_range(0, 3));
            if (it % 2 == 0) begin
                for (int i = 0; i <= len; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'($urandom_range(0, 15)); end
                do_write(addr, len, burst, 4'(it), -1, 1'b1, resp, id_o, ok);
                n_checks++;
                if (!ok || resp !== 2'b00 || id_o !== 4'(it)) begin
                    n_fail++; $display("FAIL rand_write%0d: got ok=%0d bresp=%b bid=%h expected 1/00/%h", it, ok, resp, id_o, 4'(it));
                end
                apply_wlog();
            end else begin
                do_read(addr, len, burst, 4'(it), 2, nb, st, id_o, arc);
                n_checks++;
                if (nb != len + 1 || !st || id_o !== 4'(it)) begin
                    n_fail++; $display("FAIL rand_read%0d_shape: got beats=%0d stable=%0d rid=%h expected %0d/1/%h",
                                       it, nb, st, id_o, len + 1, 4'(it));
                end
                for (int i = 0; i < nb; i++) begin
                    n_checks++;
                    if (rd_data[i] !== mdl[idx_of(addr, i, burst)] || rd_last[i] !== (i == len)) begin
                        n_fail++;
                        $display("FAIL rand_read%0d_beat%0d: got %h last=%b expected %h last=%b",
                                 it, i, rd_data[i], rd_last[i], mdl[idx_of(addr, i, burst)], i == len);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midread();
        int t;
        logic [49:0] got;
        bus.arid = 4'd2; bus.araddr = 32'h1C0; bus.arlen = 8'd7; bus.arsize = 3'd2;
        bus.arburst = 2'b01; bus.arvalid = 1'b1; bus.rready = 1'b0;
        t = 0;
        while (!bus.arready && t < 50) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        n_checks++;
        if (bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL midread_active: got %b expected 1", bus.rvalid); end
        rst = 1'b1;
        @(posedge clk); #1;
        got = {bus.arready, bus.awready, bus.rvalid, bus.rlast, bus.wready, bus.bvalid,
               bus.rid, bus.bid, bus.rresp, bus.bresp, bus.rdata};
        n_checks++;
        if (got !== 50'd0) begin n_fail++; $display("FAIL midread_reset_outputs: got %h expected 0", got); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.arready !== 1'b1 || bus.rvalid !== 1'b0) begin
            n_fail++; $display("FAIL midread_after_release: got arready=%b rvalid=%b expected 1/0", bus.arready, bus.rvalid);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        lbus.arid = '0; lbus.araddr = '0; lbus.arlen = '0; lbus.arsize = '0; lbus.arburst = '0; lbus.arvalid = 1'b0;
        lbus.rready = 1'b0;
        lbus.awid = '0; lbus.awaddr = '0; lbus.awlen = '0; lbus.awsize = '0; lbus.awburst = '0; lbus.awvalid = 1'b0;
        lbus.wdata = '0; lbus.wstrb = '0; lbus.wlast = 1'b0; lbus.wvalid = 1'b0; lbus.bready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_burst16();
        test_partial_strobe();
        test_latency();
        test_wrap();
        test_errors();
        test_concurrent();
        test_random();
        test_reset_midread();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
